// File: rtl/ex_stall_pkg.sv
// ex_stall_pkg
// Shared definitions for the EX-stage stall controller: FSM state encoding,
// multi-cycle op codes, ID register-type codes, default latencies and the
// helper that converts an op latency into the down-counter load value.
package ex_stall_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mc_state_e;

    // EX_MC_OP codes
    localparam logic [1:0] MC_OP_IDIV  = 2'b00;
    localparam logic [1:0] MC_OP_FDIV  = 2'b01;
    localparam logic [1:0] MC_OP_FSQRT = 2'b10;
    localparam logic [1:0] MC_OP_RSVD  = 2'b11;

    // ID_REG_TYPE codes
    localparam logic [1:0] RT_INT      = 2'b00; // int rs1/rs2
    localparam logic [1:0] RT_INT_FLT  = 2'b01; // int rs1, float rs2
    localparam logic [1:0] RT_FLT2     = 2'b10; // float rs1/rs2
    localparam logic [1:0] RT_FLT3     = 2'b11; // float rs1/rs2/rs3

    // Default total EX occupancy in cycles
    localparam int DEF_DIV_LAT   = 32;
    localparam int DEF_FDIV_LAT  = 24;
    localparam int DEF_FSQRT_LAT = 28;

    localparam int CNT_W = 16;

    // Cycle T (IDLE, start seen) and the DONE cycle are not RUN cycles,
    // so RUN lasts LAT-2 cycles.
    function automatic logic [CNT_W-1:0] lat_to_load(input int lat);
        return CNT_W'(lat - 2);
    endfunction

endpackage

// File: rtl/mc_latency_counter.sv
// mc_latency_counter
// Down-counter tracking the remaining RUN cycles of a multi-cycle EX op.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - force count to 0 (flush); highest priority
//   load        - load load_val
//   dec         - decrement by one (saturates at 0)
//   load_val    - value to load
//   zero        - the decrement taken this cycle brings the count to 0,
//                 i.e. this is the last RUN cycle
module mc_latency_counter
    import ex_stall_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Looking one step ahead lets the FSM leave RUN on the exact cycle the
    // count reaches zero instead of one cycle late.
    assign zero = (count_reg <= CNT_W'(1));

endmodule

// File: rtl/ex_stall_controller.sv
// ex_stall_controller
// Pipeline stall/bubble generator for the EX stage: holds EX for the full
// latency of integer divide, FDIV.S and FSQRT.S, and inserts a one-cycle
// bubble for load-use hazards between EX and ID.
// Optional feature macro: EX_STALL_PERF_EN adds the STALL_CYCLES counter.
// Ports:
//   CLK, RESET                     - clock, asynchronous active-low reset
//   ID_ADDR1..3, ID_REG_TYPE       - sources / register-file types of ID instr
//   EX_ADDR, EX_WRITE_EN,
//   EX_F_WRITE_EN, EX_MEM_READ     - destination and write/load flags in EX
//   EX_MC_START, EX_MC_OP          - EX instruction is multi-cycle, which op
//   FLUSH                          - pipeline flush, zeroes all outputs
//   PC_STALL, IF_ID_STALL,
//   ID_EX_STALL, ID_EX_BUBBLE,
//   EX_MEM_BUBBLE                  - pipeline control
//   MC_BUSY, MC_DONE               - multi-cycle status
//   STALL_CYCLES (EX_STALL_PERF_EN)- saturating count of PC_STALL cycles
module ex_stall_controller
    import ex_stall_pkg::*;
#(
    parameter int DIV_LAT   = DEF_DIV_LAT,
    parameter int FDIV_LAT  = DEF_FDIV_LAT,
    parameter int FSQRT_LAT = DEF_FSQRT_LAT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_ADDR1,
    input  logic [4:0]  ID_ADDR2,
    input  logic [4:0]  ID_ADDR3,
    input  logic [1:0]  ID_REG_TYPE,
    input  logic [4:0]  EX_ADDR,
    input  logic        EX_WRITE_EN,
    input  logic        EX_F_WRITE_EN,
    input  logic        EX_MEM_READ,
    input  logic        EX_MC_START,
    input  logic [1:0]  EX_MC_OP,
    input  logic        FLUSH,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        ID_EX_STALL,
    output logic        ID_EX_BUBBLE,
    output logic        EX_MEM_BUBBLE,
    output logic        MC_BUSY,
    output logic        MC_DONE
`ifdef EX_STALL_PERF_EN
    ,
    output logic [31:0] STALL_CYCLES
`endif
);

    mc_state_e        state_reg;
    logic [CNT_W-1:0] load_val;
    logic             cnt_zero;
    logic             active;
    logic             start_legal;
    logic             mc_stall;
    logic             load_use;
    logic             lu_stall;

    // ------------------------------------------------------------------
    // Load-use hazard detection, one lane per source operand
    // ------------------------------------------------------------------
    logic [4:0] src_addr [3];
    logic [2:0] src_int_used;
    logic [2:0] src_flt_used;
    logic [2:0] src_hit;

    always_comb begin
        src_addr[0]     = ID_ADDR1;
        src_addr[1]     = ID_ADDR2;
        src_addr[2]     = ID_ADDR3;
        src_int_used    = 3'b000;
        src_flt_used    = 3'b000;
        src_int_used[0] = ~ID_REG_TYPE[1];
        src_flt_used[0] =  ID_REG_TYPE[1];
        src_int_used[1] = (ID_REG_TYPE == RT_INT);
        src_flt_used[1] = (ID_REG_TYPE != RT_INT);
        src_flt_used[2] = (ID_REG_TYPE == RT_FLT3);
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            // x0 is hard-wired zero so it never hazards; f0 is a real register.
            assign src_hit[gi] = (src_addr[gi] == EX_ADDR) &&
                ((src_int_used[gi] && EX_WRITE_EN && (src_addr[gi] != 5'd0)) ||
                 (src_flt_used[gi] && EX_F_WRITE_EN));
        end
    endgenerate

    assign load_use = EX_MEM_READ && (|src_hit);

    // ------------------------------------------------------------------
    // Stall / bubble outputs (combinational so the start cycle is covered)
    // ------------------------------------------------------------------
    // Outputs are gated by reset as well, so holding RESET low silences
    // the controller even while start/hazard inputs are active.
    assign active      = RESET && !FLUSH;
    assign start_legal = (state_reg == ST_IDLE) && EX_MC_START && (EX_MC_OP != MC_OP_RSVD);
    assign mc_stall    = active && (start_legal || (state_reg == ST_RUN));
    assign lu_stall    = active && load_use && !mc_stall;

    assign PC_STALL      = mc_stall || lu_stall;
    assign IF_ID_STALL   = mc_stall || lu_stall;
    assign ID_EX_STALL   = mc_stall;
    assign EX_MEM_BUBBLE = mc_stall;
    assign ID_EX_BUBBLE  = lu_stall;
    assign MC_BUSY       = mc_stall;
    assign MC_DONE       = active && (state_reg == ST_DONE);

    // ------------------------------------------------------------------
    // Latency counter and FSM
    // ------------------------------------------------------------------
    always_comb begin
        load_val = '0;
        case (EX_MC_OP)
            MC_OP_IDIV:  load_val = lat_to_load(DIV_LAT);
            MC_OP_FDIV:  load_val = lat_to_load(FDIV_LAT);
            MC_OP_FSQRT: load_val = lat_to_load(FSQRT_LAT);
            default:     load_val = '0;
        endcase
    end

    mc_latency_counter u_cnt (
        .clk      (CLK),
        .rst_n    (RESET),
        .clr      (FLUSH),
        .load     (start_legal),
        .dec      (state_reg == ST_RUN),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= ST_IDLE;
        end else if (FLUSH) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_legal) begin
                        // A 2-cycle op has no RUN cycles at all.
                        state_reg <= (load_val == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_zero) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef EX_STALL_PERF_EN
    // ------------------------------------------------------------------
    // Saturating stall-cycle counter, cleared only by reset
    // ------------------------------------------------------------------
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cycles_reg <= '0;
        end else if (PC_STALL && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign STALL_CYCLES = stall_cycles_reg;
`endif

endmodule

// File: doc/ex_stall_controller.md
EX_STALL_CONTROLLER -- requirements
Module: ex_stall_controller

Interface
- REQ-001 SHALL have parameter DIV_LAT, default 32, meaning total EX occupancy in cycles of integer DIV/DIVU/REM/REMU.
- REQ-002 SHALL have parameter FDIV_LAT, default 24, meaning total EX occupancy in cycles of FDIV.S.
- REQ-003 SHALL have parameter FSQRT_LAT, default 28, meaning total EX occupancy in cycles of FSQRT.S; all LAT parameters >= 2.
- REQ-004 SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
- REQ-005 SHALL have port RESET, input, 1 bit, asynchronous active-low reset.
- REQ-006 SHALL have ports ID_ADDR1/ID_ADDR2/ID_ADDR3, input, 5 bits each, source addresses of the instruction in ID.
- REQ-007 SHALL have port ID_REG_TYPE, input, 2 bits, register-type code of the ID instruction (00 int, 01 int rs1/float rs2, 10 float rs1/rs2, 11 float rs1..rs3).
- REQ-008 SHALL have ports EX_ADDR, input, 5 bits; EX_WRITE_EN, EX_F_WRITE_EN, EX_MEM_READ, input, 1 bit each: destination and write/load flags of the EX instruction.
- REQ-009 SHALL have ports EX_MC_START, input, 1 bit, and EX_MC_OP, input, 2 bits (00 IDIV, 01 FDIV, 10 FSQRT, 11 reserved): the EX instruction is multi-cycle.
- REQ-010 SHALL have port FLUSH, input, 1 bit, pipeline flush request.
- REQ-011 SHALL have outputs PC_STALL, IF_ID_STALL, ID_EX_STALL, ID_EX_BUBBLE, EX_MEM_BUBBLE, MC_BUSY, MC_DONE, 1 bit each.

Function
- REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
- REQ-013 IDLE with EX_MC_START=1 and EX_MC_OP!=11 SHALL go to RUN, loading the counter with LAT-2 of the selected op; EX_MC_OP=11 SHALL be ignored.
- REQ-014 RUN SHALL decrement the counter each cycle; at counter 0 go to DONE; DONE SHALL go to IDLE unconditionally.
- REQ-015 Stall set (PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_BUBBLE) SHALL be asserted combinationally in IDLE when a legal EX_MC_START is seen, and throughout RUN; deasserted in DONE.
- REQ-016 An MC op starting at cycle T SHALL therefore hold EX for exactly LAT cycles (T..T+LAT-1), with MC_DONE=1 only in cycle T+LAT-1.
- REQ-017 MC_BUSY SHALL equal (state==RUN) or the IDLE start condition of REQ-013.
- REQ-018 Load-use hazard SHALL be detected when EX_MEM_READ=1 and a used source matches EX_ADDR with matching register file: ADDR1 int if ID_REG_TYPE[1]=0 else float; ADDR2 int if ID_REG_TYPE=00 else float; ADDR3 float only if ID_REG_TYPE=11; int match needs EX_WRITE_EN, float needs EX_F_WRITE_EN.
- REQ-019 Integer address 0 SHALL never produce a hazard; float f0 SHALL.
- REQ-020 Load-use hazard SHALL assert PC_STALL, IF_ID_STALL, ID_EX_BUBBLE for that cycle only; ID_EX_STALL and EX_MEM_BUBBLE SHALL stay 0.
- REQ-021 When MC stall and load-use coincide, MC stall SHALL take priority and ID_EX_BUBBLE SHALL be 0.
- REQ-022 FLUSH=1 SHALL force every output to 0 in the same cycle and send FSM to IDLE with counter 0 on the next edge; no MC_DONE pulse for an aborted op.

Reset
- REQ-023 RESET low SHALL immediately force state IDLE, counter 0, all outputs 0, perf counter 0.
- REQ-024 Reset asserted mid-RUN SHALL abort the op without MC_DONE; first cycle after release behaves as IDLE.

Configuration
- REQ-025 With EX_STALL_PERF_EN defined, SHALL add output STALL_CYCLES, 32 bits, counting cycles with PC_STALL=1, saturating at 0xFFFFFFFF, cleared by reset only.
- REQ-026 Without EX_STALL_PERF_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
- REQ-027 Shared package ex_stall_pkg SHALL hold FSM state encodings, EX_MC_OP codes, ID_REG_TYPE codes, default latencies.
- REQ-028 Latency down-counter SHALL be a sub-module mc_latency_counter (load, decrement, zero flag).

Verification
- REQ-029 IDIV start at T, DIV_LAT=32 -> stall set high T..T+30, MC_DONE=1 only at T+31, IDLE at T+32.
- REQ-030 Load to x5 in EX, ID uses x5 as ADDR2, REG_TYPE=00 -> PC_STALL/IF_ID_STALL/ID_EX_BUBBLE high one cycle; same with EX_ADDR=0 -> no stall.
- REQ-031 FLW to f3 in EX (EX_F_WRITE_EN=1), ID REG_TYPE=11, ADDR3=3 -> load-use stall; REG_TYPE=10 -> no stall.
- REQ-032 FDIV start, FLUSH at 5th RUN cycle -> outputs 0 that cycle, IDLE next, no MC_DONE.
- REQ-033 RESET low during FSQRT RUN -> outputs 0 immediately, no MC_DONE after release.
- REQ-034 With EX_STALL_PERF_EN, one IDIV (32) plus one load-use -> STALL_CYCLES=32.
